// File: rtl/arbitro_pop_pkg.sv
// Shared definitions for the pop-side arbiter: FSM encodings and the
// word-format defaults common to the arbiter, the pop counter and the FIFOs.
package arbitro_pop_pkg;

   localparam int FIFO_UNITS_DEF = 4;
   localparam int INDEX_DEF      = 2;
   localparam int DATA_WIDTH_DEF = 10;

   // The destination field sits in the top INDEX bits of each word
   localparam int DEST_MSB_DEF   = DATA_WIDTH_DEF - 1;

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_INIT   = 2'd1,
      ST_IDLE   = 2'd2,
      ST_ACTIVE = 2'd3
   } state_t;

endpackage

// File: rtl/arbitro_pop_rr_prio_enc.sv
// Round-robin priority encoder: picks the first set request after ptr,
// wrapping modulo 4, and reports it as one-hot, valid flag and index.
module rr_prio_enc (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [3:0] grant,
   output logic       valid,
   output logic [1:0] idx
);

   logic [1:0] cand;

   always_comb begin
      valid = 1'b0;
      idx   = ptr;
      cand  = ptr;
      // ptr itself is searched last, so the previous winner has lowest priority
      for (int k = 1; k <= 4; k++) begin
         cand = ptr + 2'(k);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
      grant = valid ? (4'b0001 << idx) : 4'b0000;
   end

endmodule

// File: rtl/arbitro_pop.sv
// Round-robin arbiter draining 4 show-ahead input FIFOs into 4 output FIFOs,
// routing by the destination field and holding back words bound for almost-full FIFOs.
module arbitro_pop
   import arbitro_pop_pkg::*;
#(
   parameter int FIFO_UNITS = FIFO_UNITS_DEF,
   parameter int INDEX      = INDEX_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [FIFO_UNITS-1:0] empty,
   input  logic [FIFO_UNITS-1:0] almost_full,
   input  logic [DATA_WIDTH-1:0] data_in_0,
   input  logic [DATA_WIDTH-1:0] data_in_1,
   input  logic [DATA_WIDTH-1:0] data_in_2,
   input  logic [DATA_WIDTH-1:0] data_in_3,
   output logic                  pop_0,
   output logic                  pop_1,
   output logic                  pop_2,
   output logic                  pop_3,
   output logic                  push_0,
   output logic                  push_1,
   output logic                  push_2,
   output logic                  push_3,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  IDLE
);

   state_t            state;
   logic [INDEX-1:0]  ptr;
   logic [DATA_WIDTH-1:0] din [4];
   logic [INDEX-1:0]  dest [4];
   logic [3:0]        eligible;
   logic [3:0]        req;
   logic [3:0]        grant;
   logic              gvalid;
   logic [1:0]        gidx;
   logic [3:0]        push_vec;
   logic              arb_en;

   assign din[0] = data_in_0;
   assign din[1] = data_in_1;
   assign din[2] = data_in_2;
   assign din[3] = data_in_3;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         dest[i]     = din[i][DATA_WIDTH-1 -: INDEX];
         eligible[i] = !empty[i] && !almost_full[dest[i]];
      end
   end

   // Gating on state also makes the strobes fall as soon as reset forces RESET
   assign arb_en = (state == ST_IDLE) || (state == ST_ACTIVE);
   assign req    = eligible & {4{arb_en}};

   rr_prio_enc u_enc (
      .req   (req),
      .ptr   (ptr),
      .grant (grant),
      .valid (gvalid),
      .idx   (gidx)
   );

   assign push_vec = gvalid ? (4'b0001 << dest[gidx]) : 4'b0000;
   assign data_out = gvalid ? din[gidx] : '0;

   assign pop_0  = grant[0];
   assign pop_1  = grant[1];
   assign pop_2  = grant[2];
   assign pop_3  = grant[3];
   assign push_0 = push_vec[0];
   assign push_1 = push_vec[1];
   assign push_2 = push_vec[2];
   assign push_3 = push_vec[3];

   // A blocked non-empty input keeps the arbiter ACTIVE so the counter does not see IDLE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_RESET;
         ptr   <= '1;
         IDLE  <= 1'b0;
      end else begin
         case (state)
            ST_RESET: begin
               state <= ST_INIT;
               IDLE  <= 1'b0;
            end
            ST_INIT: begin
               state <= ST_IDLE;
               IDLE  <= 1'b1;
            end
            ST_IDLE: begin
               if (|eligible) begin
                  state <= ST_ACTIVE;
                  IDLE  <= 1'b0;
               end
            end
            ST_ACTIVE: begin
               if (!(|eligible) && (&empty)) begin
                  state <= ST_IDLE;
                  IDLE  <= 1'b1;
               end
            end
            default: begin
               state <= ST_RESET;
               IDLE  <= 1'b0;
            end
         endcase
         if (gvalid)
            ptr <= gidx;
      end
   end

endmodule
